// File: rtl/coherence_fsm.sv
// MSI coherence next-state/output logic for one cache block slot.
// Decodes a snooped bus message or a local CPU request and registers the reaction.
module coherence_fsm #(
   parameter logic [2:0] PROC_ID = 3'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  state,
   input  logic [21:0] cdb,
   input  logic        listen,
   output logic [1:0]  newState,
   output logic [21:0] emit,
   output logic        dataWB,
   output logic        abortMem
);

   typedef enum logic [1:0] {
      ST_I = 2'b00,
      ST_S = 2'b01,
      ST_M = 2'b10,
      ST_X = 2'b11
   } blk_state_t;

   localparam logic [21:0] CDB_IDLE   = 22'h3FFFFF;
   localparam logic [1:0]  OP_RD_MISS = 2'b00;
   localparam logic [1:0]  OP_WR_MISS = 2'b01;
   localparam logic [1:0]  OP_INV     = 2'b10;

   logic [1:0]  w_op;
   logic        w_hit;
   blk_state_t  w_cur;
   blk_state_t  w_next;
   logic        w_emit_en;
   logic [1:0]  w_emit_op;
   logic        w_wb;
   logic        w_abort;
   logic [21:0] w_emit;

   blk_state_t  r_new_state;
   logic [21:0] r_emit;
   logic        r_data_wb;
   logic        r_abort_mem;

   assign w_op  = cdb[21:20];
   assign w_hit = cdb[19];

   // Illegal state encoding behaves as Invalid.
   always_comb begin
      w_cur = ST_I;
      case (state)
         2'b01:   w_cur = ST_S;
         2'b10:   w_cur = ST_M;
         default: w_cur = ST_I;
      endcase
   end

   // Next-state and side-effect decode for snoop and CPU modes.
   always_comb begin
      w_next    = w_cur;
      w_emit_en = 1'b0;
      w_emit_op = OP_RD_MISS;
      w_wb      = 1'b0;
      w_abort   = 1'b0;
      if (cdb == CDB_IDLE) begin
         w_next = w_cur;
      end else if (listen) begin
         // Snoop: tags already matched by the parent; never emits.
         case (w_op)
            2'b00: begin
               case (w_cur)
                  ST_S: w_next = ST_S;
                  ST_M: begin
                     w_next  = ST_S;
                     w_wb    = 1'b1;
                     w_abort = 1'b1;
                  end
                  default: w_next = ST_I;
               endcase
            end
            2'b01: begin
               case (w_cur)
                  ST_M: begin
                     w_next  = ST_I;
                     w_wb    = 1'b1;
                     w_abort = 1'b1;
                  end
                  default: w_next = ST_I;
               endcase
            end
            2'b10: begin
               w_next = ST_I;
            end
            default: w_next = w_cur;
         endcase
      end else begin
         case (w_op)
            2'b00: begin
               case (w_cur)
                  ST_S: begin
                     w_next = ST_S;
                     if (!w_hit) begin
                        w_emit_en = 1'b1;
                        w_emit_op = OP_RD_MISS;
                     end else begin
                        w_emit_en = 1'b0;
                     end
                  end
                  ST_M: begin
                     if (!w_hit) begin
                        w_next    = ST_S;
                        w_wb      = 1'b1;
                        w_emit_en = 1'b1;
                        w_emit_op = OP_RD_MISS;
                     end else begin
                        w_next = ST_M;
                     end
                  end
                  default: begin
                     w_next    = ST_S;
                     w_emit_en = 1'b1;
                     w_emit_op = OP_RD_MISS;
                  end
               endcase
            end
            2'b01: begin
               w_next = ST_M;
               case (w_cur)
                  ST_S: begin
                     w_emit_en = 1'b1;
                     w_emit_op = w_hit ? OP_INV : OP_WR_MISS;
                  end
                  ST_M: begin
                     if (!w_hit) begin
                        w_wb      = 1'b1;
                        w_emit_en = 1'b1;
                        w_emit_op = OP_WR_MISS;
                     end else begin
                        w_emit_en = 1'b0;
                     end
                  end
                  default: begin
                     w_emit_en = 1'b1;
                     w_emit_op = OP_WR_MISS;
                  end
               endcase
            end
            default: w_next = w_cur;
         endcase
      end
   end

   assign w_emit = w_emit_en ? {w_emit_op, 1'b0, PROC_ID, cdb[15:13], 13'd0} : CDB_IDLE;

   // Output registers; reset overrides any bus activity in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_new_state <= ST_I;
         r_emit      <= CDB_IDLE;
         r_data_wb   <= 1'b0;
         r_abort_mem <= 1'b0;
      end else begin
         r_new_state <= w_next;
         r_emit      <= w_emit;
         r_data_wb   <= w_wb;
         r_abort_mem <= w_abort;
      end
   end

   assign newState = r_new_state;
   assign emit     = r_emit;
   assign dataWB   = r_data_wb;
   assign abortMem = r_abort_mem;

endmodule

// File: tb/tb_coherence_fsm.sv
// Bench for coherence_fsm: directed MSI cases then random traffic against a rule-level model.
module tb_coherence_fsm;

   localparam logic [2:0]  PID  = 3'd2;
   localparam logic [21:0] IDLE = 22'h3FFFFF;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  state;
   logic [21:0] cdb;
   logic        listen;
   logic [1:0]  newState;
   logic [21:0] emit;
   logic        dataWB;
   logic        abortMem;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [1:0]  ns;
      logic [21:0] em;
      logic        wb;
      logic        ab;
   } exp_t;

   coherence_fsm #(.PROC_ID(PID)) dut (
      .clock    (clock),
      .reset    (reset),
      .state    (state),
      .cdb      (cdb),
      .listen   (listen),
      .newState (newState),
      .emit     (emit),
      .dataWB   (dataWB),
      .abortMem (abortMem)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
   endtask

   // States as integers: 0 = I, 1 = S, 2 = M. Dirty data lives only in M.
   function automatic exp_t model(input logic [1:0] st_in, input logic [21:0] c,
                                  input logic lis, input logic rst);
      exp_t e;
      int   st;
      int   op;
      bit   wr, miss, send;
      logic [1:0] bop;
      st   = (st_in == 2'd3) ? 0 : int'(st_in);
      op   = int'(c[21:20]);
      e.ns = 2'(st);
      e.em = IDLE;
      e.wb = 1'b0;
      e.ab = 1'b0;
      if (rst) begin
         e.ns = 2'd0;
         return e;
      end
      if (c == IDLE) return e;
      if (lis) begin
         if (op == 3 || st == 0) return e;
         e.ns = (op == 0) ? 2'd1 : 2'd0;
         e.wb = (st == 2) && (op != 2);
         e.ab = e.wb;
         return e;
      end
      if (op >= 2) return e;
      wr   = (op == 1);
      miss = (st == 0) || !c[19];
      if (wr) e.ns = 2'd2;
      else if (st == 2 && !miss) e.ns = 2'd2;
      else e.ns = 2'd1;
      e.wb = (st == 2) && miss;
      send = 1'b1;
      if (miss) bop = wr ? 2'b01 : 2'b00;
      else if (wr && st == 1) bop = 2'b10;
      else begin
         bop  = 2'b00;
         send = 1'b0;
      end
      if (send) e.em = {bop, 1'b0, PID, c[15:13], 13'd0};
      return e;
   endfunction

   task automatic step(input logic [1:0] st, input logic [21:0] c, input logic lis, input logic rst);
      exp_t e;
      @(negedge clock);
      state  = st;
      cdb    = c;
      listen = lis;
      reset  = rst;
      e = model(st, c, lis, rst);
      @(posedge clock);
      #1;
      check("newState", 32'(newState), 32'(e.ns));
      check("emit",     32'(emit),     32'(e.em));
      check("dataWB",   32'(dataWB),   32'(e.wb));
      check("abortMem", 32'(abortMem), 32'(e.ab));
   endtask

   initial begin
      logic [21:0] rc;
      reset  = 1'b1;
      state  = 2'b00;
      cdb    = IDLE;
      listen = 1'b0;
      // Reset wins over a live snoop hit on a Modified block.
      step(2'b10, 22'h010000, 1'b1, 1'b1);
      step(2'b10, 22'h010000, 1'b1, 1'b0);
      step(2'b01, IDLE,       1'b1, 1'b0);
      step(2'b01, {2'b10, 1'b0, 3'b001, 3'b001, 13'd0}, 1'b1, 1'b0);
      step(2'b00, {2'b10, 1'b0, 3'b001, 3'b001, 13'd0}, 1'b1, 1'b0);
      step(2'b01, {2'b01, 1'b1, 3'b000, 3'b001, 13'd0}, 1'b0, 1'b0);
      step(2'b10, {2'b00, 1'b0, 3'b000, 3'b011, 13'd0}, 1'b0, 1'b0);
      step(2'b10, {2'b01, 1'b0, 3'b100, 3'b111, 13'd0}, 1'b1, 1'b0);
      step(2'b10, {2'b10, 1'b0, 3'b100, 3'b111, 13'd0}, 1'b1, 1'b0);
      for (int s = 0; s < 4; s++) begin
         step(2'(s), IDLE, 1'b0, 1'b0);
         step(2'(s), IDLE, 1'b1, 1'b0);
      end
      for (int i = 0; i < 400; i++) begin
         rc = 22'($urandom);
         if ($urandom_range(0, 7) == 0) rc = IDLE;
         step(2'($urandom_range(0, 3)), rc, 1'($urandom), ($urandom_range(0, 31) == 0));
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
